// File: rtl/npu_act_pkg.sv
// ----------------------------------------------------------------------------
// npu_act_pkg
//   Shared constants for the activation path: fp16 literals and the
//   activation sequencer FSM state encoding (2 bits).
// ----------------------------------------------------------------------------
package npu_act_pkg;

    localparam logic [15:0] FP16_ONE  = 16'h3C00;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC
    } seq_state_t;

endpackage

// File: rtl/act_seq_fifo.sv
// ----------------------------------------------------------------------------
// act_seq_fifo
//   Synchronous FIFO holding {last, fp16 data} entries for the activation
//   sequencer. Occupancy is a registered count so full/empty never depend
//   combinationally on the same-cycle push/pop.
// Ports
//   clk       rising-edge clock
//   reset_b   synchronous reset, active high
//   i_push    write request (ignored when full)
//   i_wdata   entry to write
//   i_pop     read request (ignored when empty)
//   o_rdata   head entry (valid when not empty)
//   o_full    no free entries
//   o_empty   no stored entries
//   o_level   number of stored entries
// ----------------------------------------------------------------------------
module act_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage has no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/activation_sequencer.sv
// ----------------------------------------------------------------------------
// activation_sequencer
//   Streams fp16 neuron values from an input FIFO through the sigmoid
//   activator one element at a time and presents each result on a
//   ready/valid output register.
//
//   state | meaning
//   IDLE  | waiting for a queued element and a free output slot
//   ISSUE | act_start asserted for one cycle, operand held on act_neuron_val
//   WAIT  | waiting for act_valid (or the watchdog when enabled)
//
// Configuration macro
//   ACT_TIMEOUT_EN  adds a WAIT watchdog (TIMEOUT_CYCLES) and the sticky
//                   timeout_err port; on expiry a qNaN result is emitted.
// Ports
//   clk, reset_b              clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last      input element stream
//   out_valid/out_ready/out_data/out_last  result stream
//   act_start, act_neuron_val              request to the activator
//   act_valid, act_result                  response from the activator
//   busy      work queued, in flight, or result pending
//   done      one-cycle pulse after the last result of a vector is taken
//   count     results accepted in the current vector
//   timeout_err  sticky watchdog flag (ACT_TIMEOUT_EN only)
// ----------------------------------------------------------------------------
module activation_sequencer
    import npu_act_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 12
`ifdef ACT_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             act_start,
    output logic [15:0]      act_neuron_val,
    input  logic             act_valid,
    input  logic [15:0]      act_result,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
`ifdef ACT_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [16:0]      w_fifo_rdata;
    logic [LVL_W-1:0] w_fifo_level;
    logic             w_push;
    logic             w_pop;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_result_ld;

    logic [15:0]      r_op_data;
    logic             r_op_last;
    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic             r_out_last;
    logic             r_done;
    logic [CNT_W-1:0] r_count;

`ifdef ACT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]  r_wait_cnt;
    logic             r_timeout_err;
    logic             w_timeout;
`endif

    assign in_ready = ~w_fifo_full;
    assign w_push   = in_valid & in_ready;

    act_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .i_push  (w_push),
        .i_wdata ({in_last, in_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    assign w_accept    = r_out_valid & out_ready;
    // The slot counts as free when the held result leaves this same cycle.
    assign w_slot_free = ~r_out_valid | out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_result_ld = 1'b0;
`ifdef ACT_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && w_slot_free) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (act_valid) begin
                    w_result_ld = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef ACT_TIMEOUT_EN
                else if (r_wait_cnt == '0) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_state     <= ST_IDLE;
            r_op_data   <= '0;
            r_op_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_accept & r_out_last;

            // Operand register only loads on a pop, so it is frozen through ISSUE/WAIT.
            if (w_pop) begin
                {r_op_last, r_op_data} <= w_fifo_rdata;
            end

            if (w_result_ld) begin
                r_out_data  <= act_result;
                r_out_last  <= r_op_last;
                r_out_valid <= 1'b1;
            end
`ifdef ACT_TIMEOUT_EN
            else if (w_timeout) begin
                r_out_data  <= FP16_QNAN;
                r_out_last  <= r_op_last;
                r_out_valid <= 1'b1;
            end
`endif
            else if (w_accept) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_count <= r_out_last ? '0 : r_count + CNT_W'(1);
            end
        end
    end

`ifdef ACT_TIMEOUT_EN
    // Down-counter loaded while issuing; reaching zero in WAIT is the timeout.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= TO_W'(TIMEOUT_CYCLES - 1);
            end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - TO_W'(1);
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`endif

    assign act_start      = (r_state == ST_ISSUE);
    assign act_neuron_val = r_op_data;
    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_last       = r_out_last;
    assign done           = r_done;
    assign count          = r_count;
    assign busy           = (w_fifo_level != '0) || (r_state != ST_IDLE) || r_out_valid;

endmodule
